// File: rtl/e_gates_reduce.sv
// e_gates_reduce: parallel reduction-AND / reduction-OR / reduction-XOR of
// one B-bit operand, each built as a balanced tree of 2-input gates, with
// all three flags registered behind a single-cycle valid stage.

// GateTreeLevel: one level of the three gate trees. It pairs adjacent bits
// with 2-input gates, forwards an unpaired top bit unchanged, and recurses
// on the half-width result until a single bit remains.
module GateTreeLevel #(
   parameter int W = 5
) (
   input  logic [W-1:0] andIn_i,
   input  logic [W-1:0] orIn_i,
   input  logic [W-1:0] xorIn_i,
   output logic         andOut_o,
   output logic         orOut_o,
   output logic         xorOut_o
);

   localparam int NW = (W + 1) / 2;

   generate
      if (W == 1) begin : gLeaf
         assign andOut_o = andIn_i[0];
         assign orOut_o  = orIn_i[0];
         assign xorOut_o = xorIn_i[0];
      end else begin : gNode
         logic [NW-1:0] andNext;
         logic [NW-1:0] orNext;
         logic [NW-1:0] xorNext;

         for (genvar i = 0; i < W / 2; i++) begin : gPair
            assign andNext[i] = andIn_i[2*i] & andIn_i[2*i+1];
            assign orNext[i]  = orIn_i[2*i]  | orIn_i[2*i+1];
            assign xorNext[i] = xorIn_i[2*i] ^ xorIn_i[2*i+1];
         end

         if (W % 2 == 1) begin : gOdd
            assign andNext[NW-1] = andIn_i[W-1];
            assign orNext[NW-1]  = orIn_i[W-1];
            assign xorNext[NW-1] = xorIn_i[W-1];
         end

         GateTreeLevel #(.W(NW)) uNext (
            .andIn_i  (andNext),
            .orIn_i   (orNext),
            .xorIn_i  (xorNext),
            .andOut_o (andOut_o),
            .orOut_o  (orOut_o),
            .xorOut_o (xorOut_o)
         );
      end
   endgenerate

endmodule

module e_gates_reduce #(
   parameter int B = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [B-1:0] in,
   input  logic         in_valid,
   output logic         and_out,
   output logic         or_out,
   output logic         xor_out,
   output logic         out_valid
);

   logic treeAnd;
   logic treeOr;
   logic treeXor;

   logic andOut_q, andOut_d;
   logic orOut_q, orOut_d;
   logic xorOut_q, xorOut_d;
   logic validOut_q, validOut_d;

   GateTreeLevel #(.W(B)) uTree (
      .andIn_i  (in),
      .orIn_i   (in),
      .xorIn_i  (in),
      .andOut_o (treeAnd),
      .orOut_o  (treeOr),
      .xorOut_o (treeXor)
   );

   // Load fresh tree results when an operand is offered, otherwise hold the
   // last flags; the valid flag simply follows in_valid one cycle later.
   always_comb begin
      andOut_d   = andOut_q;
      orOut_d    = orOut_q;
      xorOut_d   = xorOut_q;
      validOut_d = in_valid;
      if (in_valid) begin
         andOut_d = treeAnd;
         orOut_d  = treeOr;
         xorOut_d = treeXor;
      end
   end

   // Result registers; reset clears them immediately and discards any
   // operand presented while it is asserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         andOut_q   <= 1'b0;
         orOut_q    <= 1'b0;
         xorOut_q   <= 1'b0;
         validOut_q <= 1'b0;
      end else begin
         andOut_q   <= andOut_d;
         orOut_q    <= orOut_d;
         xorOut_q   <= xorOut_d;
         validOut_q <= validOut_d;
      end
   end

   assign and_out   = andOut_q;
   assign or_out    = orOut_q;
   assign xor_out   = xorOut_q;
   assign out_valid = validOut_q;

endmodule

// File: tb/tb_e_gates_reduce.sv
// Testbench for e_gates_reduce: directed vectors at B=5 plus the B=1 and
// B=8 width corners, followed by a randomised run against a reference model.

module tb_e_gates_reduce;

   logic       clk;
   logic       rst;

   logic [4:0] in5;
   logic       valid5;
   logic       and5, or5, xor5, outValid5;

   logic [0:0] in1;
   logic       valid1;
   logic       and1, or1, xor1, outValid1;

   logic [7:0] in8;
   logic       valid8;
   logic       and8, or8, xor8, outValid8;

   int checkCount;
   int errorCount;

   logic       expAnd, expOr, expXor, expValid;
   logic [4:0] randIn;
   logic       randValid;

   e_gates_reduce #(.B(5)) uDut5 (
      .clk(clk), .rst(rst), .in(in5), .in_valid(valid5),
      .and_out(and5), .or_out(or5), .xor_out(xor5), .out_valid(outValid5)
   );

   e_gates_reduce #(.B(1)) uDut1 (
      .clk(clk), .rst(rst), .in(in1), .in_valid(valid1),
      .and_out(and1), .or_out(or1), .xor_out(xor1), .out_valid(outValid1)
   );

   e_gates_reduce #(.B(8)) uDut8 (
      .clk(clk), .rst(rst), .in(in8), .in_valid(valid8),
      .and_out(and8), .or_out(or8), .xor_out(xor8), .out_valid(outValid8)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value with its expected value and log mismatches
   task automatic checkOutput(input string tag, input logic [3:0] observed,
                              input logic [3:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
      end
   endtask

   // Drive one B=5 operand away from the edge, then sample just after capture
   task automatic applyStimulus(input logic [4:0] value, input logic vld);
      @(negedge clk);
      in5    = value;
      valid5 = vld;
      @(posedge clk);
      #1;
   endtask

   // Drive the width-corner instances and sample just after capture
   task automatic applyCorner(input logic v1, input logic [7:0] v8);
      @(negedge clk);
      in1    = v1;
      valid1 = 1'b1;
      in8    = v8;
      valid8 = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Directed sequence followed by randomised checks
   initial begin
      checkCount = 0;
      errorCount = 0;
      rst    = 1'b1;
      in5    = '0; valid5 = 1'b0;
      in1    = '0; valid1 = 1'b0;
      in8    = '0; valid8 = 1'b0;
      #12;
      checkOutput("reset_b5", {and5, or5, xor5, outValid5}, 4'b0000);
      checkOutput("reset_b8", {and8, or8, xor8, outValid8}, 4'b0000);

      @(negedge clk);
      rst = 1'b0;

      // Get outputs to 1 then assert reset asynchronously mid-cycle
      applyStimulus(5'b11111, 1'b1);
      checkOutput("pre_reset_ones", {and5, or5, xor5, outValid5}, 4'b1111);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_reset", {and5, or5, xor5, outValid5}, 4'b0000);
      // Operand offered while reset is held must be discarded
      applyStimulus(5'b11111, 1'b1);
      checkOutput("reset_discard", {and5, or5, xor5, outValid5}, 4'b0000);
      @(negedge clk);
      rst    = 1'b0;
      valid5 = 1'b0;
      applyStimulus(5'b11111, 1'b0);
      checkOutput("post_reset_idle1", {and5, or5, xor5, outValid5}, 4'b0000);
      applyStimulus(5'b10101, 1'b0);
      checkOutput("post_reset_idle2", {and5, or5, xor5, outValid5}, 4'b0000);

      // All zeros then all ones on consecutive cycles
      applyStimulus(5'b00000, 1'b1);
      checkOutput("zeros", {and5, or5, xor5, outValid5}, 4'b0001);
      applyStimulus(5'b11111, 1'b1);
      checkOutput("ones", {and5, or5, xor5, outValid5}, 4'b1111);

      // Back-to-back mixed patterns
      applyStimulus(5'b01010, 1'b1);
      checkOutput("b2b_01010", {and5, or5, xor5, outValid5}, 4'b0101);
      applyStimulus(5'b10011, 1'b1);
      checkOutput("b2b_10011", {and5, or5, xor5, outValid5}, 4'b0111);
      applyStimulus(5'b00010, 1'b1);
      checkOutput("b2b_00010", {and5, or5, xor5, outValid5}, 4'b0111);
      applyStimulus(5'b11011, 1'b1);
      checkOutput("b2b_11011", {and5, or5, xor5, outValid5}, 4'b0101);

      // Hold: results must survive input changes while in_valid is low
      applyStimulus(5'b10011, 1'b1);
      checkOutput("hold_capture", {and5, or5, xor5, outValid5}, 4'b0111);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(5'b11111, 1'b0);
         checkOutput($sformatf("hold_%0d", k), {and5, or5, xor5, outValid5}, 4'b0110);
      end

      // Width corners
      applyCorner(1'b1, 8'hFF);
      checkOutput("b1_one", {and1, or1, xor1, outValid1}, 4'b1111);
      checkOutput("b8_ff", {and8, or8, xor8, outValid8}, 4'b1101);
      applyCorner(1'b0, 8'h80);
      checkOutput("b1_zero", {and1, or1, xor1, outValid1}, 4'b0001);
      checkOutput("b8_80", {and8, or8, xor8, outValid8}, 4'b0111);
      applyCorner(1'b1, 8'h5A);
      checkOutput("b8_5a", {and8, or8, xor8, outValid8}, 4'b0101);

      // Random operands with random valid against the reduction operators
      expAnd   = and5;
      expOr    = or5;
      expXor   = xor5;
      expValid = outValid5;
      for (int n = 0; n < 1000; n++) begin
         randIn    = 5'($urandom_range(0, 31));
         randValid = 1'($urandom_range(0, 1));
         applyStimulus(randIn, randValid);
         if (randValid) begin
            expAnd = &randIn;
            expOr  = |randIn;
            expXor = ^randIn;
         end
         expValid = randValid;
         checkOutput($sformatf("rand_%0d", n), {and5, or5, xor5, outValid5},
                     {expAnd, expOr, expXor, expValid});
         checkOutput("and_le_or", {3'b000, (!and5 || or5)}, 4'b0001);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
